// File: rtl/if_fetch_stage_pkg.sv
// Shared constants, encodings and payload types for the instruction fetch stage.
package if_fetch_stage_pkg;

    localparam int unsigned XLEN  = 16;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 8;

    // Bit positions inside IF_branch_select
    localparam int unsigned SEL_BL  = 2;
    localparam int unsigned SEL_BEQ = 1;
    localparam int unsigned SEL_BR  = 0;

    localparam logic [XLEN-1:0] NOP_ENC      = 16'h0000;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 16'h0000;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus1;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/if_fetch_stage_next_pc.sv
// Stateless next-PC selection: redirect target, sequential increment or hold.
module if_next_pc_sel
    import if_fetch_stage_pkg::*;
(
    input  logic             run,
    input  logic             redirect,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic [SEL_W-1:0] branch_select,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  branch_target,
    input  logic [XLEN-1:0]  branch_return_addr,
    output logic [XLEN-1:0]  pc_plus1_c,
    output logic [XLEN-1:0]  next_pc_c
);

    always_comb begin
        pc_plus1_c = pc + XLEN'(1);
        next_pc_c  = pc;
        if (run) begin
            // Redirect outranks stall and memory wait; select 000 refetches the current PC.
            if (redirect) begin
                if (branch_select[SEL_BL] || branch_select[SEL_BEQ]) begin
                    next_pc_c = branch_target;
                end else if (branch_select[SEL_BR]) begin
                    next_pc_c = branch_return_addr;
                end
            end else if (!stall && imem_ready) begin
                next_pc_c = pc_plus1_c;
            end
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and redirect counter.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             IF_ID_sync_nop,
    input  logic [SEL_W-1:0] IF_branch_select,
    input  logic [XLEN-1:0]  branch_return_addr,
    input  logic [XLEN-1:0]  branch_target,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [XLEN-1:0]  imem_rdata,
    input  logic             imem_ready,
    output logic [XLEN-1:0]  IF_ID_instr,
    output logic [XLEN-1:0]  IF_ID_pc,
    output logic [XLEN-1:0]  IF_ID_pc_plus1,
    output logic             IF_ID_valid,
    output logic [CNT_W-1:0] flush_count
);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pc_plus1_c;
    if_id_t           if_id_q, if_id_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             run_c;

    assign run_c = (state_q == ST_RUN);

    if_next_pc_sel u_next_pc (
        .run                (run_c),
        .redirect           (IF_ID_sync_nop),
        .stall              (stall),
        .imem_ready         (imem_ready),
        .branch_select      (IF_branch_select),
        .pc                 (pc_q),
        .branch_target      (branch_target),
        .branch_return_addr (branch_return_addr),
        .pc_plus1_c         (pc_plus1_c),
        .next_pc_c          (pc_d)
    );

    // Next-state and IF/ID update; bubbles keep the previous pc fields.
    always_comb begin
        state_d       = state_q;
        if_id_d       = if_id_q;
        flush_count_d = flush_count_q;
        case (state_q)
            ST_BOOT: begin
                state_d       = ST_RUN;
                if_id_d.instr = NOP_INSTR;
                if_id_d.valid = 1'b0;
            end
            ST_RUN: begin
                if (IF_ID_sync_nop) begin
                    if_id_d.instr = NOP_INSTR;
                    if_id_d.valid = 1'b0;
                    if (flush_count_q != '1) begin
                        flush_count_d = flush_count_q + CNT_W'(1);
                    end
                end else if (!stall) begin
                    if (!imem_ready) begin
                        if_id_d.instr = NOP_INSTR;
                        if_id_d.valid = 1'b0;
                    end else begin
                        if_id_d.instr    = imem_rdata;
                        if_id_d.pc       = pc_q;
                        if_id_d.pc_plus1 = pc_plus1_c;
                        if_id_d.valid    = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            if_id_q       <= '{instr: NOP_INSTR, pc: '0, pc_plus1: '0, valid: 1'b0};
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_q       <= if_id_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign imem_addr      = pc_q;
    assign IF_ID_instr    = if_id_q.instr;
    assign IF_ID_pc       = if_id_q.pc;
    assign IF_ID_pc_plus1 = if_id_q.pc_plus1;
    assign IF_ID_valid    = if_id_q.valid;
    assign flush_count    = flush_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus random traffic against a cycle model.
module tb_if_fetch_stage;

    localparam logic [15:0] TB_RESET_PC = 16'h0000;
    localparam logic [15:0] TB_NOP      = 16'h7E00;
    localparam logic [15:0] MEM_BASE    = 16'hA000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        sync_nop;
    logic [2:0]  sel;
    logic [15:0] ret_addr;
    logic [15:0] tgt;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] IF_ID_instr;
    logic [15:0] IF_ID_pc;
    logic [15:0] IF_ID_pc_plus1;
    logic        IF_ID_valid;
    logic [7:0]  flush_count;

    int vectors;
    int miscompares;

    // Reference model state
    logic [15:0] m_pc, m_instr, m_ipc, m_ipc1;
    logic        m_valid, m_boot;
    int          m_flush;

    if_fetch_stage #(.RESET_PC(TB_RESET_PC), .NOP_INSTR(TB_NOP)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .stall              (stall),
        .IF_ID_sync_nop     (sync_nop),
        .IF_branch_select   (sel),
        .branch_return_addr (ret_addr),
        .branch_target      (tgt),
        .imem_addr          (imem_addr),
        .imem_rdata         (imem_rdata),
        .imem_ready         (imem_ready),
        .IF_ID_instr        (IF_ID_instr),
        .IF_ID_pc           (IF_ID_pc),
        .IF_ID_pc_plus1     (IF_ID_pc_plus1),
        .IF_ID_valid        (IF_ID_valid),
        .flush_count        (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word at address a is MEM_BASE + a
    assign imem_rdata = MEM_BASE + imem_addr;

    task automatic model_reset();
        m_pc = TB_RESET_PC; m_instr = TB_NOP; m_ipc = 16'h0; m_ipc1 = 16'h0;
        m_valid = 1'b0; m_boot = 1'b1; m_flush = 0;
    endtask

    // One clock of the fetch stage, written from the behavioural rules
    task automatic model_update();
        if (m_boot) begin
            m_boot = 1'b0; m_instr = TB_NOP; m_valid = 1'b0;
        end else if (sync_nop) begin
            m_flush = (m_flush < 255) ? m_flush + 1 : 255;
            m_instr = TB_NOP; m_valid = 1'b0;
            if (sel[2] || sel[1]) m_pc = tgt;
            else if (sel[0])      m_pc = ret_addr;
        end else if (stall) begin
            // everything holds
        end else if (!imem_ready) begin
            m_instr = TB_NOP; m_valid = 1'b0;
        end else begin
            m_ipc = m_pc; m_ipc1 = m_pc + 16'd1; m_instr = MEM_BASE + m_pc;
            m_valid = 1'b1; m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic n, input logic [2:0] se,
                          input logic [15:0] t, input logic [15:0] r, input logic rdy);
        stall = s; sync_nop = n; sel = se; tgt = t; ret_addr = r; imem_ready = rdy;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_in(1'b0, 1'b0, 3'b000, 16'h0, 16'h0, 1'b1);
        assert_reset();
        vectors++; if (imem_addr !== TB_RESET_PC) begin miscompares++; $display("FAIL rst_imem_addr: got %h want %h", imem_addr, TB_RESET_PC); end
        vectors++; if (IF_ID_instr !== TB_NOP) begin miscompares++; $display("FAIL rst_instr: got %h want %h", IF_ID_instr, TB_NOP); end
        vectors++; if (IF_ID_pc !== 16'h0 || IF_ID_pc_plus1 !== 16'h0) begin miscompares++; $display("FAIL rst_pcs: got %h/%h want 0000/0000", IF_ID_pc, IF_ID_pc_plus1); end
        vectors++; if (IF_ID_valid !== 1'b0 || flush_count !== 8'h00) begin miscompares++; $display("FAIL rst_valid_flush: got %b/%h want 0/00", IF_ID_valid, flush_count); end
        release_reset();
        // BOOT cycle: redirect must be ignored
        set_in(1'b0, 1'b1, 3'b100, 16'h1111, 16'h2222, 1'b1);
        step();
        vectors++; if (imem_addr !== TB_RESET_PC) begin miscompares++; $display("FAIL boot_imem_addr: got %h want %h", imem_addr, TB_RESET_PC); end
        vectors++; if (flush_count !== 8'h00) begin miscompares++; $display("FAIL boot_flush: got %h want 00", flush_count); end
        vectors++; if (IF_ID_valid !== 1'b0 || IF_ID_instr !== TB_NOP) begin miscompares++; $display("FAIL boot_bubble: got %b/%h want 0/%h", IF_ID_valid, IF_ID_instr, TB_NOP); end
    endtask

    task automatic test_linear();
        set_in(1'b0, 1'b0, 3'b000, 16'h0, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (IF_ID_pc !== 16'(i) || IF_ID_instr !== 16'hA000 + 16'(i) || IF_ID_valid !== 1'b1) begin
                miscompares++; $display("FAIL linear_%0d: got pc=%h instr=%h v=%b want pc=%h instr=%h v=1", i, IF_ID_pc, IF_ID_instr, IF_ID_valid, 16'(i), 16'hA000 + 16'(i));
            end
        end
    endtask

    task automatic test_bl_redirect();
        set_in(1'b0, 1'b0, 3'b000, 16'h0, 16'h0, 1'b1);
        step(); step();
        vectors++; if (imem_addr !== 16'h0005) begin miscompares++; $display("FAIL bl_pre_pc: got %h want 0005", imem_addr); end
        set_in(1'b0, 1'b1, 3'b100, 16'h0040, 16'h9999, 1'b1);
        step();
        vectors++; if (imem_addr !== 16'h0040) begin miscompares++; $display("FAIL bl_imem_addr: got %h want 0040", imem_addr); end
        vectors++; if (IF_ID_valid !== 1'b0 || IF_ID_instr !== TB_NOP) begin miscompares++; $display("FAIL bl_bubble: got %b/%h want 0/%h", IF_ID_valid, IF_ID_instr, TB_NOP); end
        vectors++; if (flush_count !== 8'h01) begin miscompares++; $display("FAIL bl_flush: got %h want 01", flush_count); end
    endtask

    task automatic test_br_stall();
        set_in(1'b1, 1'b1, 3'b001, 16'h5555, 16'h1234, 1'b1);
        step();
        vectors++; if (imem_addr !== 16'h1234) begin miscompares++; $display("FAIL br_imem_addr: got %h want 1234", imem_addr); end
        vectors++; if (IF_ID_valid !== 1'b0 || flush_count !== 8'h02) begin miscompares++; $display("FAIL br_bubble_flush: got %b/%h want 0/02", IF_ID_valid, flush_count); end
        set_in(1'b1, 1'b0, 3'b111, 16'h5555, 16'h4321, 1'b1);
        step();
        vectors++; if (imem_addr !== 16'h1234 || IF_ID_valid !== 1'b0 || flush_count !== 8'h02) begin
            miscompares++; $display("FAIL stall_hold: got %h/%b/%h want 1234/0/02", imem_addr, IF_ID_valid, flush_count);
        end
        set_in(1'b0, 1'b0, 3'b111, 16'h5555, 16'h4321, 1'b1);
        step();
        vectors++; if (IF_ID_pc !== 16'h1234 || IF_ID_valid !== 1'b1 || imem_addr !== 16'h1235) begin
            miscompares++; $display("FAIL post_stall_fetch: got pc=%h v=%b addr=%h want 1234/1/1235", IF_ID_pc, IF_ID_valid, imem_addr);
        end
        // Stall with valid data in IF/ID must keep all of it
        set_in(1'b1, 1'b0, 3'b000, 16'h0, 16'h0, 1'b1);
        step();
        vectors++; if (IF_ID_pc !== 16'h1234 || IF_ID_pc_plus1 !== 16'h1235 || IF_ID_instr !== 16'hB234 || IF_ID_valid !== 1'b1 || imem_addr !== 16'h1235) begin
            miscompares++; $display("FAIL stall_keep: got %h/%h/%h/%b addr=%h want 1234/1235/b234/1 addr=1235", IF_ID_pc, IF_ID_pc_plus1, IF_ID_instr, IF_ID_valid, imem_addr);
        end
    endtask

    task automatic test_illegal_select();
        set_in(1'b0, 1'b1, 3'b111, 16'h0777, 16'h2222, 1'b1);
        step();
        vectors++; if (imem_addr !== 16'h0777 || flush_count !== 8'h03) begin miscompares++; $display("FAIL sel111: got %h/%h want 0777/03", imem_addr, flush_count); end
        set_in(1'b0, 1'b1, 3'b000, 16'h3333, 16'h2222, 1'b1);
        step();
        vectors++; if (imem_addr !== 16'h0777 || IF_ID_valid !== 1'b0 || flush_count !== 8'h04) begin
            miscompares++; $display("FAIL sel000: got %h/%b/%h want 0777/0/04", imem_addr, IF_ID_valid, flush_count);
        end
    endtask

    task automatic test_wrap_wait();
        set_in(1'b0, 1'b1, 3'b010, 16'hFFFF, 16'h0, 1'b1);
        step();
        vectors++; if (imem_addr !== 16'hFFFF) begin miscompares++; $display("FAIL beq_to_ffff: got %h want ffff", imem_addr); end
        set_in(1'b0, 1'b0, 3'b000, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++; if (imem_addr !== 16'hFFFF || IF_ID_valid !== 1'b0 || IF_ID_instr !== TB_NOP) begin
                miscompares++; $display("FAIL wait_%0d: got %h/%b/%h want ffff/0/%h", i, imem_addr, IF_ID_valid, IF_ID_instr, TB_NOP);
            end
        end
        imem_ready = 1'b1;
        step();
        vectors++; if (IF_ID_pc !== 16'hFFFF || IF_ID_pc_plus1 !== 16'h0000 || imem_addr !== 16'h0000) begin
            miscompares++; $display("FAIL wrap: got pc=%h pc1=%h addr=%h want ffff/0000/0000", IF_ID_pc, IF_ID_pc_plus1, imem_addr);
        end
        vectors++; if (IF_ID_instr !== 16'h9FFF || IF_ID_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_instr: got %h/%b want 9fff/1", IF_ID_instr, IF_ID_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in(($urandom_range(4) == 0), ($urandom_range(5) == 0), 3'($urandom_range(7)),
                   16'($urandom), 16'($urandom), ($urandom_range(3) != 0));
            step();
            vectors++; if (imem_addr !== m_pc) begin miscompares++; $display("FAIL rnd_addr c%0d: got %h want %h", c, imem_addr, m_pc); end
            vectors++; if (IF_ID_instr !== m_instr || IF_ID_valid !== m_valid) begin
                miscompares++; $display("FAIL rnd_ifid c%0d: got %h/%b want %h/%b", c, IF_ID_instr, IF_ID_valid, m_instr, m_valid);
            end
            vectors++; if (flush_count !== 8'(m_flush)) begin miscompares++; $display("FAIL rnd_flush c%0d: got %h want %h", c, flush_count, 8'(m_flush)); end
            if (m_valid) begin
                vectors++; if (IF_ID_pc !== m_ipc || IF_ID_pc_plus1 !== m_ipc1) begin
                    miscompares++; $display("FAIL rnd_pcs c%0d: got %h/%h want %h/%h", c, IF_ID_pc, IF_ID_pc_plus1, m_ipc, m_ipc1);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 300; i++) begin
            set_in(1'($urandom), 1'b1, 3'($urandom_range(7)), 16'($urandom), 16'($urandom), 1'($urandom));
            step();
        end
        vectors++; if (flush_count !== 8'hFF) begin miscompares++; $display("FAIL sat_flush: got %h want ff", flush_count); end
        vectors++; if (imem_addr !== m_pc) begin miscompares++; $display("FAIL sat_addr: got %h want %h", imem_addr, m_pc); end
        // Redirect still requested while reset hits
        assert_reset();
        vectors++; if (flush_count !== 8'h00 || imem_addr !== TB_RESET_PC || IF_ID_valid !== 1'b0) begin
            miscompares++; $display("FAIL midrst_async: got %h/%h/%b want 00/%h/0", flush_count, imem_addr, IF_ID_valid, TB_RESET_PC);
        end
        release_reset();
        step();
        vectors++; if (flush_count !== 8'h00 || imem_addr !== TB_RESET_PC || IF_ID_valid !== 1'b0) begin
            miscompares++; $display("FAIL midrst_boot: got %h/%h/%b want 00/%h/0", flush_count, imem_addr, IF_ID_valid, TB_RESET_PC);
        end
        set_in(1'b0, 1'b0, 3'b000, 16'h0, 16'h0, 1'b1);
        step();
        vectors++; if (IF_ID_pc !== TB_RESET_PC || IF_ID_valid !== 1'b1 || IF_ID_instr !== MEM_BASE + TB_RESET_PC) begin
            miscompares++; $display("FAIL midrst_first_fetch: got pc=%h v=%b instr=%h want %h/1/%h", IF_ID_pc, IF_ID_valid, IF_ID_instr, TB_RESET_PC, MEM_BASE + TB_RESET_PC);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 3'b000, 16'h0, 16'h0, 1'b1);
        model_reset();
        test_reset();
        test_linear();
        test_bl_redirect();
        test_br_stall();
        test_illegal_select();
        test_wrap_wait();
        test_random();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
